r_burst_arbiter: RTL and testbench

Read-side burst arbiter for the asynchronous FIFO read domain. It shares a single FIFO read port (`r_en`/`r_empty`/`r_data`) between `N_REQ` consumers. Each consumer asks for a burst of 1..`BURST_MAX` words; the block grants round-robin, pops words only while the FIFO is non-empty, and tags each delivered word with the winner's index. It sits between the FIFO read pointer/empty logic and the downstream consumers, entirely in the `r_clk` domain.

---
 rtl/r_burst_arbiter_pkg.sv | 22 ++
 rtl/r_burst_arbiter_if.sv | 31 +++
 rtl/r_burst_arbiter_rr.sv | 29 ++
 rtl/r_burst_arbiter.sv | 149 ++++++++++++++
 tb/tb_r_burst_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/r_burst_arbiter_pkg.sv
// Shared types and width constants for the read-side burst arbiter.
package r_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_MAX  = 8;
    localparam int DEF_TIMEOUT    = 16;

    localparam int LEN_WIDTH = $clog2(DEF_BURST_MAX);
    localparam int ID_WIDTH  = $clog2(DEF_N_REQ);

    // Round-robin successor: the index after the last grant gets top priority.
    function automatic int next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/r_burst_arbiter_if.sv
// Bus bundle between the FIFO read port, the consumers and the burst arbiter.
interface r_burst_arbiter_if import r_arb_pkg::*; #(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = r_arb_pkg::LEN_WIDTH,
    parameter int ID_WIDTH   = r_arb_pkg::ID_WIDTH
);

    logic [N_REQ-1:0]           req;
    logic [N_REQ*LEN_WIDTH-1:0] req_len;
    logic                       r_empty;
    logic [DATA_WIDTH-1:0]      r_data;
    logic                       r_en;
    logic [N_REQ-1:0]           grant;
    logic                       dout_valid;
    logic [DATA_WIDTH-1:0]      dout_data;
    logic [ID_WIDTH-1:0]        dout_id;
    logic [N_REQ-1:0]           done;
    logic                       dout_abort;

    modport master (
        output req, req_len, r_empty, r_data,
        input  r_en, grant, dout_valid, dout_data, dout_id, done, dout_abort
    );

    modport slave (
        input  req, req_len, r_empty, r_data,
        output r_en, grant, dout_valid, dout_data, dout_id, done, dout_abort
    );

endinterface

// File: rtl/r_burst_arbiter_rr.sv
// Combinational one-hot round-robin picker; i_ptr is the index with top priority.
module rr_arbiter import r_arb_pkg::*; #(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx
);

    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_rot_gnt;

    // Rotate so the priority index sits at bit 0, take the lowest set bit, rotate back.
    assign w_rot     = N_REQ'({i_req, i_req} >> i_ptr);
    assign w_rot_gnt = w_rot & (~w_rot + N_REQ'(1));
    assign o_gnt     = N_REQ'(({w_rot_gnt, w_rot_gnt} << i_ptr) >> N_REQ);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (o_gnt[i]) begin
                o_idx = o_idx | ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/r_burst_arbiter.sv
// Read-domain burst arbiter sharing one FIFO read port among N_REQ consumers.
// Optional empty-stall abort is built when R_ARB_TIMEOUT_EN is defined.
module r_burst_arbiter import r_arb_pkg::*; #(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_MAX  = DEF_BURST_MAX,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              r_clk,
    input  logic              r_rst,
    r_burst_arbiter_if.slave  bus
);

    localparam int LEN_W = $clog2(BURST_MAX);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = LEN_W + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_REQ-1:0]      r_grant;
    logic [N_REQ-1:0]      r_done;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_owner;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_dout_valid;
    logic [DATA_WIDTH-1:0] r_dout_data;
    logic [ID_W-1:0]       r_dout_id;

    logic [N_REQ-1:0]      w_win_gnt;
    logic [ID_W-1:0]       w_win_idx;
    logic                  w_pop;
    logic                  w_start;
    logic                  w_last;
    logic                  w_to_hit;
    logic [LEN_W-1:0]      w_len [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_len
        assign w_len[g] = bus.req_len[g*LEN_W +: LEN_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_win_gnt),
        .o_idx (w_win_idx)
    );

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = BURST;
            BURST:   if (w_last || w_to_hit) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pops are gated by the registered empty flag, never by the FIFO's own guard.
    always_comb begin
        w_pop   = 1'b0;
        w_start = 1'b0;
        if (r_state == BURST) begin
            w_pop = ~bus.r_empty;
        end else begin
            w_start = |bus.req;
        end
    end

    assign w_last = w_pop && (r_cnt == CNT_W'(1));

`ifdef R_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_abort;

    assign w_to_hit = (r_state == BURST) && bus.r_empty && (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge r_clk) begin
        if (r_rst || r_state != BURST || w_pop) begin
            r_to_cnt <= '0;
        end else if (bus.r_empty) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_to_hit;
        end
    end

    assign bus.dout_abort = r_abort;
`else
    assign w_to_hit       = 1'b0;
    assign bus.dout_abort = 1'b0;
`endif

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_grant      <= '0;
            r_done       <= '0;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
            r_dout_id    <= '0;
        end else begin
            r_done       <= '0;
            r_dout_valid <= w_pop;
            if (w_pop) begin
                r_dout_data <= bus.r_data;
                r_dout_id   <= r_owner;
                r_cnt       <= r_cnt - CNT_W'(1);
            end
            if (w_start) begin
                r_grant <= w_win_gnt;
                r_owner <= w_win_idx;
                r_cnt   <= CNT_W'(w_len[w_win_idx]) + CNT_W'(1);
                r_ptr   <= ID_W'(next_idx(int'(w_win_idx), N_REQ));
            end
            if (w_last || w_to_hit) begin
                r_grant <= '0;
                r_done  <= r_grant;
            end
        end
    end

    assign bus.r_en       = w_pop;
    assign bus.grant      = r_grant;
    assign bus.done       = r_done;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_data  = r_dout_data;
    assign bus.dout_id    = r_dout_id;

endmodule

// File: tb/tb_r_burst_arbiter.sv
// Scoreboard bench for r_burst_arbiter: directed bursts against a queue-based FIFO model.
module tb_r_burst_arbiter;
    import r_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 8;
    localparam int LW = 3;
    localparam int IW = 2;
    localparam int TO = 16;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [1:0] id;
        logic [3:0] dn;
        logic       ab;
    } exp_t;

    logic r_clk = 1'b0;
    logic r_rst = 1'b1;
    always #5 r_clk = ~r_clk;

    r_burst_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

    r_burst_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM),
        .TIMEOUT    (TO)
    ) dut (
        .r_clk (r_clk),
        .r_rst (r_rst),
        .bus   (bus)
    );

    exp_t       sb_q[$];
    logic [7:0] fifo_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         pop_cnt = 0;
    logic       pop_now;
    logic [3:0] rr_exp [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void drive_fifo();
        bus.r_empty = (fifo_q.size() == 0);
        bus.r_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endfunction

    task automatic push_word(input logic [7:0] d);
        fifo_q.push_back(d);
        drive_fifo();
    endtask

    task automatic exp_word(input logic [7:0] d, input logic [1:0] id, input logic [3:0] dn);
        exp_t e;
        e.v  = 1'b1;
        e.d  = d;
        e.id = id;
        e.dn = dn;
        e.ab = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic set_len(input int idx, input logic [2:0] v);
        bus.req_len[idx*LW +: LW] = v;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || bus.grant != '0) && k < 100) begin
            @(negedge r_clk);
            k++;
        end
        chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        chk({name, "_idle"}, 32'(bus.grant), 32'd0);
        @(negedge r_clk);
    endtask

    // FIFO model: pop on the edge where r_en was high, then present the new head.
    always @(posedge r_clk) begin
        pop_now = bus.r_en;
        #1;
        if (pop_now) begin
            chk("fifo_underflow", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) begin
                void'(fifo_q.pop_front());
                pop_cnt++;
            end
        end
        drive_fifo();
    end

    always @(negedge r_clk) begin : monitor
        exp_t e;
        if (bus.r_en) chk("pop_while_empty", 32'(bus.r_empty), 32'd0);
        if (bus.grant == '0) chk("pop_while_idle", 32'(bus.r_en), 32'd0);
        if (bus.dout_valid || bus.done != '0) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: valid=%0d data=0x%0h id=%0d done=%b at %0t",
                         bus.dout_valid, bus.dout_data, bus.dout_id, bus.done, $time);
            end else begin
                e = sb_q.pop_front();
                chk("out_valid", 32'(bus.dout_valid), 32'(e.v));
                if (e.v) begin
                    chk("out_data", 32'(bus.dout_data), 32'(e.d));
                    chk("out_id", 32'(bus.dout_id), 32'(e.id));
                end
                chk("out_done", 32'(bus.done), 32'(e.dn));
                chk("out_abort", 32'(bus.dout_abort), 32'(e.ab));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req     = '0;
        bus.req_len = '0;
        drive_fifo();
        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        repeat (2) @(negedge r_clk);

        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ren", 32'(bus.r_en), 32'd0);
        chk("rst_abort", 32'(bus.dout_abort), 32'd0);
        chk("rst_data", 32'(bus.dout_data), 32'd0);
        chk("rst_id", 32'(bus.dout_id), 32'd0);
        r_rst = 1'b0;
        @(negedge r_clk);

        // single burst, owner 2, four words
        for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
        exp_word(8'h11, 2'd2, 4'b0000);
        exp_word(8'h12, 2'd2, 4'b0000);
        exp_word(8'h13, 2'd2, 4'b0000);
        exp_word(8'h14, 2'd2, 4'b0100);
        set_len(2, 3'd3);
        bus.req = 4'b0100;
        @(negedge r_clk);
        chk("t1_grant", 32'(bus.grant), 32'h4);
        chk("t1_ren", 32'(bus.r_en), 32'd1);
        bus.req = '0;
        drain("t1");
        chk("t1_fifo_left", 32'(fifo_q.size()), 32'd0);

        // round-robin from a fresh pointer, one-word bursts
        r_rst = 1'b1;
        @(negedge r_clk);
        r_rst = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
        exp_word(8'hA0, 2'd0, 4'b0001);
        exp_word(8'hA1, 2'd1, 4'b0010);
        exp_word(8'hA2, 2'd2, 4'b0100);
        exp_word(8'hA3, 2'd3, 4'b1000);
        exp_word(8'hA4, 2'd0, 4'b0001);
        bus.req_len = '0;
        bus.req     = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge r_clk);
            chk("rr_grant", 32'(bus.grant), 32'(rr_exp[c]));
            if (c == 8) bus.req = '0;
        end
        drain("rr");

        // empty stall: 2 words available, 4 requested, refill after 5 stall cycles
        push_word(8'h21);
        push_word(8'h22);
        exp_word(8'h21, 2'd1, 4'b0000);
        exp_word(8'h22, 2'd1, 4'b0000);
        exp_word(8'h23, 2'd1, 4'b0000);
        exp_word(8'h24, 2'd1, 4'b0010);
        set_len(1, 3'd3);
        bus.req = 4'b0010;
        @(negedge r_clk);
        chk("st_grant", 32'(bus.grant), 32'h2);
        bus.req = '0;
        @(negedge r_clk);
        chk("st_second_pop", 32'(bus.r_en), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge r_clk);
            chk("st_stall_ren", 32'(bus.r_en), 32'd0);
            chk("st_hold_grant", 32'(bus.grant), 32'h2);
        end
        @(negedge r_clk);
        push_word(8'h23);
        push_word(8'h24);
        drain("stall");

        // reset after two of eight pops
        for (int i = 0; i < 8; i++) push_word(8'h31 + 8'(i));
        exp_word(8'h31, 2'd3, 4'b0000);
        exp_word(8'h32, 2'd3, 4'b0000);
        set_len(3, 3'd7);
        bus.req = 4'b1000;
        @(negedge r_clk);
        chk("mr_grant", 32'(bus.grant), 32'h8);
        bus.req = '0;
        @(negedge r_clk);
        @(negedge r_clk);
        r_rst = 1'b1;
        @(negedge r_clk);
        chk("mr_ren", 32'(bus.r_en), 32'd0);
        chk("mr_grant_clr", 32'(bus.grant), 32'd0);
        chk("mr_valid", 32'(bus.dout_valid), 32'd0);
        chk("mr_no_done", 32'(bus.done), 32'd0);
        fifo_q.delete();
        push_word(8'h41);
        exp_word(8'h41, 2'd0, 4'b0001);
        bus.req_len = '0;
        bus.req     = 4'b1111;
        r_rst       = 1'b0;
        @(negedge r_clk);
        chk("mr_post_grant", 32'(bus.grant), 32'h1);
        bus.req = '0;
        drain("mr");

        // maximum length: eight pops out of nine queued words
        pop_cnt = 0;
        for (int i = 0; i < 9; i++) push_word(8'h51 + 8'(i));
        for (int i = 0; i < 7; i++) exp_word(8'h51 + 8'(i), 2'd1, 4'b0000);
        exp_word(8'h58, 2'd1, 4'b0010);
        set_len(1, 3'd7);
        bus.req = 4'b0010;
        @(negedge r_clk);
        chk("ml_grant", 32'(bus.grant), 32'h2);
        bus.req = '0;
        drain("ml");
        chk("ml_pops", 32'(pop_cnt), 32'd8);
        chk("ml_fifo_left", 32'(fifo_q.size()), 32'd1);
        fifo_q.delete();
        drive_fifo();
        @(negedge r_clk);

`ifdef R_ARB_TIMEOUT_EN
        // empty FIFO: abort after TO stall cycles, then the next requester wins
        begin
            exp_t e;
            e.v  = 1'b0;
            e.d  = 8'h00;
            e.id = 2'd0;
            e.dn = 4'b0100;
            e.ab = 1'b1;
            sb_q.push_back(e);
        end
        bus.req_len = '0;
        bus.req     = 4'b1100;
        for (int k = 0; k < TO; k++) begin
            @(negedge r_clk);
            chk("to_hold_grant", 32'(bus.grant), 32'h4);
        end
        @(negedge r_clk);
        chk("to_idle", 32'(bus.grant), 32'd0);
        @(negedge r_clk);
        chk("to_next_grant", 32'(bus.grant), 32'h8);
        bus.req = '0;
        push_word(8'h61);
        exp_word(8'h61, 2'd3, 4'b1000);
        drain("to");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
